// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side resolution signals between the core and
// the branch predictor. The core drives the master side; the predictor is the slave.
interface branch_predictor_if #(
  parameter int DATA_LEN = 32
);
  logic                hold;
  logic [DATA_LEN-1:0] if_pc;
  logic                pred_taken;
  logic [DATA_LEN-1:0] pred_target;
  logic                ex_valid;
  logic [DATA_LEN-1:0] ex_pc;
  logic                ex_is_jump;
  logic                ex_taken;
  logic [DATA_LEN-1:0] ex_target;
  logic                ex_pred_taken;
  logic [DATA_LEN-1:0] ex_pred_target;
  logic                mispredict;
  logic [DATA_LEN-1:0] redirect_pc;
  logic [DATA_LEN-1:0] branch_count;
  logic [DATA_LEN-1:0] mispredict_count;

  modport master (
    output hold, if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  hold, if_pc, ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters: combinational lookup in IF,
// training and misprediction detection from the resolved branch in EX.
module branch_predictor #(
  parameter int DATA_LEN = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int IDX_LEN  = $clog2(ENTRIES)
) (
  input  logic clk,
  input  logic reset,
  branch_predictor_if.slave bp
);
  localparam int TAG_LEN = DATA_LEN - IDX_LEN - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_LEN-1:0]  tag_q    [ENTRIES];
  logic [TAG_LEN-1:0]  tag_d    [ENTRIES];
  logic [DATA_LEN-1:0] target_q [ENTRIES];
  logic [DATA_LEN-1:0] target_d [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d    [ENTRIES];
  logic [DATA_LEN-1:0] br_cnt_q, br_cnt_d;
  logic [DATA_LEN-1:0] mp_cnt_q, mp_cnt_d;

  logic [IDX_LEN-1:0]  if_idx, ex_idx;
  logic [TAG_LEN-1:0]  if_tag, ex_tag;
  logic                if_hit, ex_hit, ex_act_taken, upd;
  logic [DATA_LEN-1:0] act_next;
  logic                unused_ok;

  function automatic logic [CNT_BITS-1:0] cnt_next(input logic [CNT_BITS-1:0] c,
                                                   input logic taken,
                                                   input logic jump);
    if (jump)  return CNT_MAX;
    if (taken) return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
    return (c == '0) ? c : c - CNT_BITS'(1);
  endfunction

  assign if_idx = bp.if_pc[IDX_LEN+1:2];
  assign if_tag = bp.if_pc[DATA_LEN-1:IDX_LEN+2];
  assign ex_idx = bp.ex_pc[IDX_LEN+1:2];
  assign ex_tag = bp.ex_pc[DATA_LEN-1:IDX_LEN+2];

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign bp.pred_taken  = if_hit && cnt_q[if_idx][CNT_BITS-1];
  assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp.if_pc + DATA_LEN'(4);

  assign ex_act_taken   = bp.ex_taken || bp.ex_is_jump;
  assign act_next       = ex_act_taken ? bp.ex_target : bp.ex_pc + DATA_LEN'(4);
  // Comparing full next-PC catches right-direction/wrong-target predictions too.
  assign bp.mispredict  = bp.ex_valid && (bp.ex_pred_target != act_next);
  assign bp.redirect_pc = bp.ex_valid ? act_next : '0;
  assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign upd            = bp.ex_valid && !bp.hold;

  assign bp.branch_count     = br_cnt_q;
  assign bp.mispredict_count = mp_cnt_q;

  assign unused_ok = ^{bp.if_pc[1:0], bp.ex_pc[1:0], bp.ex_pred_taken};

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (upd) begin
      br_cnt_d = br_cnt_q + DATA_LEN'(1);
      if (bp.mispredict) mp_cnt_d = mp_cnt_q + DATA_LEN'(1);
      if (ex_hit) begin
        cnt_d[ex_idx] = cnt_next(cnt_q[ex_idx], ex_act_taken, bp.ex_is_jump);
        if (ex_act_taken) target_d[ex_idx] = bp.ex_target;
      end else if (ex_act_taken) begin
        // Not-taken misses never allocate; they would only evict useful entries.
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = bp.ex_target;
        cnt_d[ex_idx]    = bp.ex_is_jump ? CNT_MAX : CNT_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= '0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end
endmodule
